// File: rtl/apb_master.sv
// APB3 requester: accepts one command at a time, runs SETUP/ACCESS on the APB bus,
// and returns a one-cycle response pulse carrying read data and error status.
module apb_master #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  Pclk,
    input  logic                  Prst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  Pselx,
    output logic                  Penable,
    output logic                  Pwrite,
    output logic [ADDR_WIDTH-1:0] Paddr,
    output logic [DATA_WIDTH-1:0] Pwdata,
    input  logic                  Pready,
    input  logic [DATA_WIDTH-1:0] Prdata,
    input  logic                  Pslverr,
    output logic [1:0]            dbg_state
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Value held by the counter on the edge that would make it reach TIMEOUT.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  pselx_q, pselx_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic                  timeout_hit;

    assign timeout_hit = (TIMEOUT > 0) && (wait_cnt_q == CNT_LAST);

    always_ff @(posedge Pclk or posedge Prst) begin
        if (Prst) begin
            state_q     <= IDLE;
            pselx_q     <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            pselx_q     <= pselx_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cmd_valid) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (Pready || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered APB and response values; a Pready=1 edge wins over the timeout.
    always_comb begin
        pselx_d     = pselx_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        wait_cnt_d  = wait_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    pselx_d  = 1'b1;
                end
            end
            SETUP: begin
                penable_d  = 1'b1;
                wait_cnt_d = '0;
            end
            ACCESS: begin
                if (Pready) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : Prdata;
                    rsp_err_d   = Pslverr;
                    pselx_d     = 1'b0;
                    penable_d   = 1'b0;
                end else if (timeout_hit) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    pselx_d     = 1'b0;
                    penable_d   = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: begin
                pselx_d   = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == IDLE);
        dbg_state = state_q;
    end

    assign Pselx     = pselx_q;
    assign Penable   = penable_q;
    assign Pwrite    = pwrite_q;
    assign Paddr     = paddr_q;
    assign Pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed vector table, reset corner case, and random
// transfers checked against a transfer-level reference model with a slave memory.
module tb_apb_master;

    localparam int TO = 16;

    logic        Pclk, Prst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [4:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        Pselx, Penable, Pwrite;
    logic [4:0]  Paddr;
    logic [31:0] Pwdata;
    logic        Pready, Pslverr;
    logic [31:0] Prdata;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] slv_mem[32];
    logic [31:0] ref_mem[32];

    apb_master #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .Pclk(Pclk), .Prst(Prst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite), .Paddr(Paddr),
        .Pwdata(Pwdata), .Pready(Pready), .Prdata(Prdata), .Pslverr(Pslverr),
        .dbg_state(dbg_state)
    );

    initial Pclk = 1'b0;
    always #5 Pclk = ~Pclk;
    always @(posedge Pclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One command, issued at a negedge in IDLE; the task plays the APB slave.
    task automatic xfer(input logic w, input logic [4:0] a, input logic [31:0] d,
                        input int waits, input logic serr,
                        output logic [31:0] got_rd, output logic got_err,
                        output int lat, output int pen, output int psel, output int acc);
        int k;
        bit done;
        k = 0; done = 0; pen = 0; psel = 0; lat = -1;
        got_rd = '0; got_err = 1'b0;
        check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        Pready = 1'b0; Pslverr = 1'($urandom);
        @(posedge Pclk); @(negedge Pclk);
        acc = cyc;
        // Junk on the command bus while busy must be ignored.
        cmd_valid = 1'b0; cmd_write = 1'($urandom);
        cmd_addr = 5'($urandom); cmd_wdata = $urandom;
        check("setup_phase", {Pselx, Penable, cmd_ready}, {1'b1, 1'b0, 1'b0});
        check("setup_bus", {Pwrite, Paddr, Pwdata}, {w, a, d});
        if (Pselx) psel++;
        for (int n = 0; n < 64 && !done; n++) begin
            @(posedge Pclk); @(negedge Pclk);
            if (rsp_valid) begin
                got_rd = rsp_rdata; got_err = rsp_err; lat = cyc - acc;
                check("rsp_cycle_bus", {cmd_ready, Pselx, Penable}, {1'b1, 1'b0, 1'b0});
                Pready = 1'b0; Pslverr = 1'b0;
                done = 1;
            end else begin
                if (Pselx) psel++;
                if (Penable) pen++;
                check("access_hold", {Pselx, Pwrite, Paddr, Pwdata}, {1'b1, w, a, d});
                if (k == waits) begin
                    Pready = 1'b1; Pslverr = serr;
                    if (Pwrite) begin
                        Prdata = $urandom;
                        if (!serr) slv_mem[Paddr] = Pwdata;
                    end else begin
                        Prdata = slv_mem[Paddr];
                    end
                end else begin
                    Pready = 1'b0; Pslverr = 1'($urandom); Prdata = $urandom;
                end
                k++;
            end
        end
        if (!done) begin
            errors++; checks++;
            $display("FAIL rsp_timeout: no rsp_valid within 64 cycles");
            Pready = 1'b0;
        end
    endtask

    typedef struct {
        logic        w;
        logic [4:0]  a;
        logic [31:0] d;
        int          waits;
        logic        serr;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_pen;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, pen, psel, acc, prev_acc;

        for (int i = 0; i < 32; i++) begin
            slv_mem[i] = 32'hA5A50000 | 32'(i);
            ref_mem[i] = 32'hA5A50000 | 32'(i);
        end
        Prst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        Pready = 1'b0; Prdata = '0; Pslverr = 1'b0;

        tbl[0] = '{1'b1, 5'd3,  32'hDEADBEEF, 0,  1'b0, 32'h0,        1'b0, 2,  1};
        tbl[1] = '{1'b0, 5'd3,  32'h0,        2,  1'b0, 32'hDEADBEEF, 1'b0, 4,  3};
        tbl[2] = '{1'b1, 5'd31, 32'h12345678, 0,  1'b1, 32'h0,        1'b1, 2,  1};
        tbl[3] = '{1'b0, 5'd31, 32'h0,        1,  1'b0, 32'hA5A5001F, 1'b0, 3,  2};
        tbl[4] = '{1'b0, 5'd5,  32'h0,        16, 1'b0, 32'h0,        1'b1, 17, 16};
        tbl[5] = '{1'b0, 5'd5,  32'h0,        15, 1'b0, 32'hA5A50005, 1'b0, 17, 16};
        tbl[6] = '{1'b1, 5'd5,  32'hCAFEF00D, 20, 1'b0, 32'h0,        1'b1, 17, 16};
        tbl[7] = '{1'b0, 5'd5,  32'h0,        0,  1'b0, 32'hA5A50005, 1'b0, 2,  1};
        tbl[8] = '{1'b0, 5'd3,  32'h0,        3,  1'b1, 32'hDEADBEEF, 1'b1, 5,  4};

        repeat (2) @(negedge Pclk);
        check("reset_outputs", {Pselx, Penable, Pwrite, Paddr, Pwdata},
              {1'b0, 1'b0, 1'b0, 5'd0, 32'd0});
        check("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b0, 1'b0, 32'd0});
        check("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        Prst = 1'b0;
        @(negedge Pclk);

        for (int i = 0; i < 9; i++) begin
            xfer(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].waits, tbl[i].serr, rd, er, lat, pen, psel, acc);
            check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(tbl[i].exp_rd));
            check($sformatf("vec%0d_err", i), 64'(er), 64'(tbl[i].exp_err));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(tbl[i].exp_lat));
            check($sformatf("vec%0d_penable_cycles", i), 64'(pen), 64'(tbl[i].exp_pen));
            check($sformatf("vec%0d_pselx_cycles", i), 64'(psel), 64'(tbl[i].exp_pen + 1));
            @(negedge Pclk);
            check($sformatf("vec%0d_single_pulse", i), 64'(rsp_valid), 64'd0);
        end
        ref_mem[3] = 32'hDEADBEEF;

        // Reset in the middle of ACCESS: bus drops at once and no response follows.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'd7;
        @(posedge Pclk); @(negedge Pclk);
        cmd_valid = 1'b0; Pready = 1'b0;
        repeat (2) begin @(posedge Pclk); @(negedge Pclk); end
        check("pre_reset_in_access", {Pselx, Penable}, {1'b1, 1'b1});
        #2 Prst = 1'b1;
        #1 check("mid_reset_bus", {Pselx, Penable, rsp_valid}, {1'b0, 1'b0, 1'b0});
        @(negedge Pclk);
        Prst = 1'b0; Pready = 1'b1; Prdata = 32'h11111111; Pslverr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Pclk);
            check("post_reset_quiet", {rsp_valid, Pselx, cmd_ready}, {1'b0, 1'b0, 1'b1});
        end
        Pready = 1'b0; Pslverr = 1'b0;

        // Back-to-back write/read pairs, zero wait, one transfer every 3 cycles.
        prev_acc = -1;
        for (int p = 0; p < 5; p++) begin
            logic [4:0]  ra;
            logic [31:0] rdat;
            ra = 5'($urandom_range(0, 31));
            rdat = $urandom;
            xfer(1'b1, ra, rdat, 0, 1'b0, rd, er, lat, pen, psel, acc);
            ref_mem[ra] = rdat;
            if (prev_acc >= 0) check("b2b_spacing_w", 64'(acc - prev_acc), 64'd3);
            prev_acc = acc;
            check("b2b_write_resp", {er, rd}, {1'b0, 32'd0});
            xfer(1'b0, ra, 32'h0, 0, 1'b0, rd, er, lat, pen, psel, acc);
            check("b2b_spacing_r", 64'(acc - prev_acc), 64'd3);
            prev_acc = acc;
            check("b2b_read_data", {er, rd}, {1'b0, ref_mem[ra]});
        end

        // Random transfers with random wait states and slave errors.
        for (int t = 0; t < 24; t++) begin
            logic        w, se, abort;
            logic [4:0]  ra;
            logic [31:0] dat, e_rd;
            int          wt;
            w = 1'($urandom); ra = 5'($urandom); dat = $urandom;
            wt = $urandom_range(0, 20); se = ($urandom_range(0, 3) == 0);
            abort = (wt >= TO);
            e_rd = (abort || w) ? 32'd0 : ref_mem[ra];
            xfer(w, ra, dat, wt, se, rd, er, lat, pen, psel, acc);
            if (w && !abort && !se) ref_mem[ra] = dat;
            check("rand_rdata", 64'(rd), 64'(e_rd));
            check("rand_err", 64'(er), 64'(abort || se));
            check("rand_latency", 64'(lat), abort ? 64'(TO + 1) : 64'(wt + 2));
            check("rand_penable_cycles", 64'(pen), abort ? 64'(TO) : 64'(wt + 1));
        end

        repeat (2) @(negedge Pclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master.md
# apb_master

APB requester that turns a simple single-command request interface into APB3 transfers for the downstream APB slave memory (Paddr 5-bit, 32-bit data). It sits directly upstream of the memory and drives its Pselx/Penable/Pwrite/Paddr/Pwdata, honouring Pready wait states and Pslverr. It returns read data and error status as a one-cycle response pulse, and aborts a transfer that stalls longer than a programmable timeout.

## Interface
- ADDR_WIDTH, 5, width of Paddr and cmd_addr
- DATA_WIDTH, 32, width of write/read data
- TIMEOUT, 16, max ACCESS cycles with Pready=0 before abort; 0 disables the timeout

- Pclk  input  1  clock; all logic on rising edge
- Prst  input  1  reset, asynchronous, active-high
- cmd_valid  input  1  command request
- cmd_ready  output  1  block accepts a command this cycle
- cmd_write  input  1  1=write, 0=read
- cmd_addr  input  ADDR_WIDTH  transfer address
- cmd_wdata  input  DATA_WIDTH  write data (ignored for reads)
- rsp_valid  output  1  one-cycle pulse: transfer finished
- rsp_rdata  output  DATA_WIDTH  read data, valid with rsp_valid
- rsp_err  output  1  Pslverr seen or timeout, valid with rsp_valid
- Pselx  output  1  APB select
- Penable  output  1  APB enable (ACCESS phase)
- Pwrite  output  1  APB direction
- Paddr  output  ADDR_WIDTH  APB address
- Pwdata  output  DATA_WIDTH  APB write data
- Pready  input  1  slave ready
- Prdata  input  DATA_WIDTH  slave read data
- Pslverr  input  1  slave error

## Operation
- FSM states: IDLE, SETUP, ACCESS; all APB outputs registered.
- IDLE: cmd_ready=1. On cmd_valid=1 at a rising edge: latch cmd_write/addr/wdata into Pwrite/Paddr/Pwdata, go SETUP.
- SETUP: Pselx=1, Penable=0, cmd_ready=0; unconditionally go ACCESS next edge; wait counter cleared.
- ACCESS: Pselx=1, Penable=1. At an edge with Pready=1: capture Prdata (reads; writes capture 0) into rsp_rdata, Pslverr into rsp_err, assert rsp_valid for the next cycle, deassert Pselx/Penable, go IDLE.
- ACCESS with Pready=0: increment wait counter (width clog2(TIMEOUT+1)). When counter reaches TIMEOUT (TIMEOUT>0): abort, rsp_valid=1, rsp_err=1, rsp_rdata=0, Pselx/Penable=0, go IDLE.
- Pslverr is sampled only when Pready=1 in ACCESS; ignored otherwise.
- Paddr/Pwdata/Pwrite stable from SETUP through end of ACCESS; in IDLE they hold last values.
- cmd_* sampled only when cmd_ready=1; changes at other times have no effect. No command queue: one outstanding transfer.
- rsp_valid has no backpressure; consumer must take it in its pulse cycle.

## Timing
- Reset (Prst=1, any time, async): state=IDLE, Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0; cmd_ready=1 after release. Reset mid-transfer drops Pselx/Penable immediately; no response issued.
- Zero-wait transfer: accept at edge T; SETUP in cycle T..T+1; ACCESS in T+1..T+2; Pready=1 sampled at T+2; rsp_valid high T+2..T+3; IDLE (cmd_ready=1) from T+2; next accept earliest at edge T+3. Throughput: one transfer per 3 cycles minimum.
- Each Pready=0 cycle in ACCESS adds one cycle of latency.
- Timeout: abort edge is the TIMEOUT-th consecutive edge in ACCESS with Pready=0; a Pready=1 at that same edge wins (normal completion).
- rsp_valid and cmd_ready are both high in the cycle after completion.

## Test plan
- Reset: assert Prst mid-ACCESS -> Pselx=0, Penable=0, rsp_valid=0 within same cycle, no response after release; cmd_ready=1.
- Zero-wait write cmd_addr=5'd3, cmd_wdata=32'hDEADBEEF, Pready tied 1 -> Pselx 2 cycles, Penable 1 cycle, Paddr=3, Pwdata=DEADBEEF, rsp_valid 1 cycle, rsp_err=0, rsp_rdata=0.
- Read addr 3 with slave returning 32'hDEADBEEF after 2 wait states -> Penable high 3 cycles, rsp_rdata=DEADBEEF, total latency accept-to-rsp_valid = 4 edges.
- Pslverr=1 with Pready=1 on write addr 31 -> rsp_valid=1, rsp_err=1; next command accepted normally.
- TIMEOUT=16, Pready held 0 -> abort at 16th ACCESS edge, rsp_err=1, rsp_rdata=0, Pselx=0; repeat with Pready=1 at exactly 16th edge -> rsp_err=0, data captured.
- Five back-to-back write/read pairs with random addr/data against memory model -> every read returns the data last written to that address, one transfer per 3 cycles.
